// File: rtl/vga_timing_if.sv
// Pixel-tick input and raster/timing outputs of the VGA timing generator.
interface vga_timing_if #(
  parameter int CW = 11
);
  logic          pix_en;
  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic          hsync;
  logic          vsync;
  logic          visible;
  logic          dith_h;
  logic          dith_v;
  logic          frame_start;
  logic          line_start;

  modport master (
    input  pix_en,
    output hc, vc, hsync, vsync, visible, dith_h, dith_v, frame_start, line_start
  );

  modport slave (
    output pix_en,
    input  hc, vc, hsync, vsync, visible, dith_h, dith_v, frame_start, line_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster counters plus a pix_en-gated delay line that keeps sync, visible and
// dither phase aligned with the downstream pattern/dither/output pipeline.
module vga_timing_gen #(
  parameter int H_VISIBLE = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_VISIBLE = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0,
  parameter int PIPE_DLY  = 2,
  parameter int CW        = 11
) (
  input  logic        clk,
  input  logic        rst,
  vga_timing_if.master bus
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (PIPE_DLY < 1 || PIPE_DLY > 4) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY must be in 1..4");
  end
  if ((2 ** CW) < H_TOTAL || (2 ** CW) < V_TOTAL) begin : g_bad_cw
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end

  // Decode bounds are one bit wider so an upper bound equal to 2^CW still fits.
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW:0]   H_ACT  = (CW+1)'(H_VISIBLE);
  localparam logic [CW:0]   V_ACT  = (CW+1)'(V_VISIBLE);
  localparam logic [CW:0]   HS_LO  = (CW+1)'(H_VISIBLE + H_FP);
  localparam logic [CW:0]   HS_HI  = (CW+1)'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CW:0]   VS_LO  = (CW+1)'(V_VISIBLE + V_FP);
  localparam logic [CW:0]   VS_HI  = (CW+1)'(V_VISIBLE + V_FP + V_SYNC);

  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
    logic dh;
    logic dv;
  } tap_t;

  logic [CW-1:0]         hc, vc;
  logic [CW:0]           hx, vx;
  logic                  line_start, frame_start;
  tap_t                  tap_in;
  tap_t [PIPE_DLY:1]     dly;

  assign hx = {1'b0, hc};
  assign vx = {1'b0, vc};

  always_comb begin
    tap_in     = '0;
    tap_in.hs  = (hx >= HS_LO) && (hx < HS_HI);
    tap_in.vs  = (vx >= VS_LO) && (vx < VS_HI);
    tap_in.vis = (hx < H_ACT) && (vx < V_ACT);
    tap_in.dh  = hc[0];
    tap_in.dv  = vc[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc          <= '0;
      vc          <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      dly         <= '0;
    end else begin
      // Pulses default low so they never outlast the tick that wrapped.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (bus.pix_en) begin
        dly[1] <= tap_in;
        for (int i = 2; i <= PIPE_DLY; i++) dly[i] <= dly[i-1];
        if (hc == H_LAST) begin
          hc         <= '0;
          line_start <= 1'b1;
          if (vc == V_LAST) begin
            vc          <= '0;
            frame_start <= 1'b1;
          end else begin
            vc <= vc + 1'b1;
          end
        end else begin
          hc <= hc + 1'b1;
        end
      end
    end
  end

  assign bus.hc          = hc;
  assign bus.vc          = vc;
  assign bus.hsync       = dly[PIPE_DLY].hs ? H_POL : ~H_POL;
  assign bus.vsync       = dly[PIPE_DLY].vs ? V_POL : ~V_POL;
  assign bus.visible     = dly[PIPE_DLY].vis;
  assign bus.dith_h      = dly[PIPE_DLY].dh;
  assign bus.dith_v      = dly[PIPE_DLY].dv;
  assign bus.line_start  = line_start;
  assign bus.frame_start = frame_start;
endmodule
